// File: rtl/reg_file_sb.sv
// Register file with a per-register write-back scoreboard: 2 async read ports, 1 sync write port, R0 reads 0.
// Optional feature: define REGFILE_BYPASS_EN to forward write-back data to same-cycle reads.
module reg_file_sb #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 4,
  parameter int CNT_W   = 2,
  parameter int DBG_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              busy_a,
  output logic              busy_b,
  output logic              stall,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_addr,
  output logic              iss_rdy,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              sb_err,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int              NREG    = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DATA_W-1:0] regs    [NREG];
  logic [CNT_W-1:0]  cnt     [NREG];
  logic [CNT_W-1:0]  cnt_nxt [NREG];
  logic [NREG-1:0]   inc;
  logic [NREG-1:0]   dec;
  logic              err_set;

  // A retire in the same cycle frees a slot, so a full counter can still accept an issue.
  assign iss_rdy = (cnt[iss_addr] != CNT_MAX) || (wr_en && (wr_addr == iss_addr));

  always_comb begin
    // NOTE: every variable gets a default before any conditional update, so no latch is inferred.
    inc     = '0;
    dec     = '0;
    err_set = iss_en && !iss_rdy;
    for (int i = 0; i < NREG; i++) begin
      cnt_nxt[i] = cnt[i];
      if (i != 0) begin
        inc[i] = iss_en && (iss_addr == ADDR_W'(i)) && iss_rdy;
        dec[i] = wr_en && (wr_addr == ADDR_W'(i));
      end
    end
    for (int i = 0; i < NREG; i++) begin
      if (inc[i] && !dec[i]) begin
        cnt_nxt[i] = cnt[i] + 1'b1;
      end else if (dec[i] && !inc[i]) begin
        if (cnt[i] == '0) err_set = 1'b1;
        else              cnt_nxt[i] = cnt[i] - 1'b1;
      end
    end
  end

  always_comb begin
    rd_data_a = regs[rd_addr_a];
    rd_data_b = regs[rd_addr_b];
    busy_a    = (cnt[rd_addr_a] != '0);
    busy_b    = (cnt[rd_addr_b] != '0);
`ifdef REGFILE_BYPASS_EN
    // The retiring write is forwarded, so only writes still outstanding after it count as busy.
    if (wr_en && (wr_addr == rd_addr_a) && (rd_addr_a != '0)) begin
      rd_data_a = wr_data;
      busy_a    = (cnt[rd_addr_a] > CNT_W'(1));
    end
    if (wr_en && (wr_addr == rd_addr_b) && (rd_addr_b != '0)) begin
      rd_data_b = wr_data;
      busy_b    = (cnt[rd_addr_b] > CNT_W'(1));
    end
`endif
  end

  assign stall    = busy_a || busy_b || (iss_en && !iss_rdy);
  assign dbg_data = regs[ADDR_W'(DBG_REG)];

  // R0 is reset and never written, so it reads as zero without a read-side mux.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the register array is reset on purpose; architectural state must read 0 after reset.
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
        cnt[i]  <= '0;
      end
      sb_err <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (wr_en && (wr_addr != '0)) regs[wr_addr] <= wr_data;
      for (int i = 0; i < NREG; i++) cnt[i] <= cnt_nxt[i];
      if (err_set) sb_err <= 1'b1;
    end
  end

endmodule
